// File: rtl/dqsw_train_pkg.sv
// rtl/dqsw_train_pkg.sv - shared state encoding and strobe constants for the DQSW lane trainer
package dqsw_train_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PULSE,
    SETTLE,
    SAMPLE,
    MOVE,
    DONE,
    FAIL
  } state_t;

  localparam logic [1:0] STROBE_TX = 2'b01;
  localparam logic [1:0] STROBE_OE = 2'b11;
  localparam logic [1:0] IDLE_TX   = 2'b00;

  localparam int FILTER_SAMPLES = 3;

endpackage

// File: rtl/dqsw_lane_trainer_if.sv
// rtl/dqsw_lane_trainer_if.sv - training-controller handshake plus lane IOD delay-line/TX/RX ports
interface dqsw_lane_trainer_if #(
  parameter int TAP_W = 8
);

  logic             start;
  logic             busy;
  logic             done;
  logic             pass;
  logic [TAP_W-1:0] tap_result;
  logic             DELAY_LINE_LOAD_0;
  logic             DELAY_LINE_MOVE_0;
  logic             DELAY_LINE_DIRECTION_0;
  logic             DELAY_LINE_OUT_OF_RANGE_0;
  logic             EYE_MONITOR_CLEAR_FLAGS_0;
  logic [1:0]       TX_DATA_0;
  logic [1:0]       OE_DATA_0;
  logic [1:0]       RX_DATA_0;

  modport master (
    input  start,
    input  DELAY_LINE_OUT_OF_RANGE_0,
    input  RX_DATA_0,
    output busy,
    output done,
    output pass,
    output tap_result,
    output DELAY_LINE_LOAD_0,
    output DELAY_LINE_MOVE_0,
    output DELAY_LINE_DIRECTION_0,
    output EYE_MONITOR_CLEAR_FLAGS_0,
    output TX_DATA_0,
    output OE_DATA_0
  );

  modport slave (
    output start,
    output DELAY_LINE_OUT_OF_RANGE_0,
    output RX_DATA_0,
    input  busy,
    input  done,
    input  pass,
    input  tap_result,
    input  DELAY_LINE_LOAD_0,
    input  DELAY_LINE_MOVE_0,
    input  DELAY_LINE_DIRECTION_0,
    input  EYE_MONITOR_CLEAR_FLAGS_0,
    input  TX_DATA_0,
    input  OE_DATA_0
  );

endinterface

// File: rtl/dqsw_sample_filter.sv
// rtl/dqsw_sample_filter.sv - 3-sample majority vote on write-leveling feedback (used with DQSW_TRAIN_FILTER_EN)
module dqsw_sample_filter
  import dqsw_train_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic sample_en,
  input  logic sample,
  output logic last,
  output logic vote
);

  logic [1:0] cnt;
  logic [1:0] ones;
  logic [2:0] total;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= 2'd0;
      ones <= 2'd0;
    end else if (clear) begin
      cnt  <= 2'd0;
      ones <= 2'd0;
    end else if (sample_en) begin
      cnt  <= cnt + 2'd1;
      ones <= ones + {1'b0, sample};
    end
  end

  // Vote includes the sample being taken this cycle so the decision lands on the last SAMPLE.
  assign total = {1'b0, ones} + {2'b00, sample};
  assign last  = (cnt == 2'(FILTER_SAMPLES - 1));
  assign vote  = (total >= 3'd2);

endmodule

// File: rtl/dqsw_lane_trainer.sv
// rtl/dqsw_lane_trainer.sv - DQSW write-leveling tap sweep for one byte lane; DQSW_TRAIN_FILTER_EN enables majority filtering
module dqsw_lane_trainer
  import dqsw_train_pkg::*;
#(
  parameter int MAX_TAPS   = 128,
  parameter int TAP_W      = 8,
  parameter int SETTLE_CYC = 8
) (
  input  logic                 FAB_CLK,
  input  logic                 ARST_N,
  dqsw_lane_trainer_if.master  bus
);

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;

  state_t             state;
  state_t             next_state;
  logic [TAP_W-1:0]   tap_cnt;
  logic               seen_zero;
  logic [SET_W-1:0]   settle_cnt;
  logic               fb;
  logic               fb_last;
  logic               pass_q;
  logic [TAP_W-1:0]   tap_result_q;
  logic               unused_rx_hi;

  assign unused_rx_hi = bus.RX_DATA_0[1];

`ifdef DQSW_TRAIN_FILTER_EN
  logic tap_entry;

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      tap_entry <= 1'b0;
    end else if (state == LOAD || state == MOVE) begin
      tap_entry <= 1'b1;
    end else if (state == PULSE) begin
      tap_entry <= 1'b0;
    end
  end

  dqsw_sample_filter u_filter (
    .clk       (FAB_CLK),
    .rst_n     (ARST_N),
    .clear     (state == PULSE && tap_entry),
    .sample_en (state == SAMPLE),
    .sample    (bus.RX_DATA_0[0]),
    .last      (fb_last),
    .vote      (fb)
  );
`else
  assign fb      = bus.RX_DATA_0[0];
  assign fb_last = 1'b1;
`endif

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (bus.start) next_state = LOAD;
      LOAD:    next_state = PULSE;
      PULSE:   next_state = SETTLE;
      SETTLE:  if (settle_cnt == SET_W'(SETTLE_CYC - 1)) next_state = SAMPLE;
      SAMPLE: begin
        if (!fb_last)                              next_state = PULSE;
        else if (fb && seen_zero)                  next_state = DONE;
        else if (tap_cnt == TAP_W'(MAX_TAPS - 1))  next_state = FAIL;
        else                                       next_state = MOVE;
      end
      MOVE:    next_state = bus.DELAY_LINE_OUT_OF_RANGE_0 ? FAIL : PULSE;
      DONE:    next_state = IDLE;
      FAIL:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      tap_cnt      <= '0;
      seen_zero    <= 1'b0;
      settle_cnt   <= '0;
      pass_q       <= 1'b0;
      tap_result_q <= '0;
    end else begin
      settle_cnt <= (state == SETTLE) ? settle_cnt + SET_W'(1) : '0;
      if (state == IDLE && bus.start) begin
        pass_q       <= 1'b0;
        tap_result_q <= '0;
      end
      if (state == LOAD) begin
        tap_cnt   <= '0;
        seen_zero <= 1'b0;
      end
      // A 1 only counts once a 0 has been seen, so a sweep starting past the edge keeps going.
      if (state == SAMPLE && fb_last) begin
        if (fb && seen_zero) begin
          pass_q       <= 1'b1;
          tap_result_q <= tap_cnt;
        end else if (!fb) begin
          seen_zero <= 1'b1;
        end
      end
      if (state == MOVE && !(&tap_cnt)) begin
        tap_cnt <= tap_cnt + TAP_W'(1);
      end
      if (next_state == FAIL) begin
        pass_q       <= 1'b0;
        tap_result_q <= '0;
      end
    end
  end

  // Outputs are registered from next_state so each strobe lines up with its state cycle.
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      bus.busy                      <= 1'b0;
      bus.done                      <= 1'b0;
      bus.DELAY_LINE_LOAD_0         <= 1'b0;
      bus.DELAY_LINE_MOVE_0         <= 1'b0;
      bus.DELAY_LINE_DIRECTION_0    <= 1'b0;
      bus.EYE_MONITOR_CLEAR_FLAGS_0 <= 1'b0;
      bus.TX_DATA_0                 <= IDLE_TX;
      bus.OE_DATA_0                 <= IDLE_TX;
    end else begin
      bus.busy                      <= (next_state != IDLE);
      bus.done                      <= (next_state == DONE) || (next_state == FAIL);
      bus.DELAY_LINE_LOAD_0         <= (next_state == LOAD);
      bus.DELAY_LINE_MOVE_0         <= (next_state == MOVE);
      bus.DELAY_LINE_DIRECTION_0    <= 1'b1;
      bus.EYE_MONITOR_CLEAR_FLAGS_0 <= (next_state == LOAD);
      bus.TX_DATA_0                 <= (next_state == PULSE) ? STROBE_TX : IDLE_TX;
      bus.OE_DATA_0                 <= (next_state == PULSE) ? STROBE_OE : IDLE_TX;
    end
  end

  assign bus.pass       = pass_q;
  assign bus.tap_result = tap_result_q;

endmodule
